// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared ALU control codes and divider state encoding.
package div_unit_pkg;
   localparam logic [7:0] EXE_DIV_OP  = 8'b00011010;
   localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;
   typedef enum logic [1:0] {
      DIV_IDLE = 2'b00,
      DIV_BUSY = 2'b01,
      DIV_DONE = 2'b10
   } div_state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring division iteration on {rem,quo}.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic [WIDTH-1:0] quo_next
);
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;
   // One extra bit keeps the trial exact when the shifted remainder overflows WIDTH bits
   assign shifted  = {rem, quo[WIDTH-1]};
   assign trial    = shifted - {1'b0, divisor};
   assign rem_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
   assign quo_next = {quo[WIDTH-2:0], ~trial[WIDTH]};
endmodule

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring DIV/DIVU for the EX stage with pipeline stall request.
// DIV_ZERO_FAST_EN: a zero divisor finishes in one cycle with lo=all ones, hi=dividend.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       alucontrolE,
   input  logic             validE,
   input  logic             flushE,
   input  logic             holdE,
   input  logic [WIDTH-1:0] srcaE,
   input  logic [WIDTH-1:0] srcbE,
   output logic             stall_div,
   output logic             div_ready,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   div_state_t state;
   logic [CW-1:0] count;
   logic [WIDTH-1:0] rem, quo, divisor, rem_n, quo_n, mag_a, mag_b;
   logic q_sign, r_sign, is_div, sgn, fast_zero;
   assign sgn       = alucontrolE == EXE_DIV_OP;
   assign is_div    = validE & (sgn | alucontrolE == EXE_DIVU_OP);
   assign stall_div = is_div & ~flushE & (state != DIV_DONE);
   assign mag_a     = (sgn & srcaE[WIDTH-1]) ? -srcaE : srcaE;
   assign mag_b     = (sgn & srcbE[WIDTH-1]) ? -srcbE : srcbE;
`ifdef DIV_ZERO_FAST_EN
   assign fast_zero = srcbE == '0;
`else
   assign fast_zero = 1'b0;
`endif
   div_step #(.WIDTH(WIDTH)) u_step (
      .rem     (rem),
      .quo     (quo),
      .divisor (divisor),
      .rem_next(rem_n),
      .quo_next(quo_n)
   );
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= DIV_IDLE;
         count     <= '0;
         hi_out    <= '0;
         lo_out    <= '0;
         div_ready <= 1'b0;
         rem       <= '0;
         quo       <= '0;
         divisor   <= '0;
         q_sign    <= 1'b0;
         r_sign    <= 1'b0;
      end else if (flushE) begin
         state     <= DIV_IDLE;
         div_ready <= 1'b0;
      end else begin
         case (state)
            DIV_IDLE: if (is_div) begin
               rem     <= '0;
               quo     <= mag_a;
               divisor <= mag_b;
               q_sign  <= sgn & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
               r_sign  <= sgn & srcaE[WIDTH-1];
               count   <= '0;
               state   <= fast_zero ? DIV_DONE : DIV_BUSY;
               if (fast_zero) begin
                  div_ready <= 1'b1;
                  hi_out    <= srcaE;
                  lo_out    <= '1;
               end
            end
            DIV_BUSY: begin
               rem   <= rem_n;
               quo   <= quo_n;
               count <= count + 1'b1;
               // Sign fixups are folded into the final step so DONE presents corrected results
               if (count == LAST) begin
                  state     <= DIV_DONE;
                  div_ready <= 1'b1;
                  lo_out    <= q_sign ? -quo_n : quo_n;
                  hi_out    <= r_sign ? -rem_n : rem_n;
               end
            end
            DIV_DONE: if (!holdE) begin
               state     <= DIV_IDLE;
               div_ready <= 1'b0;
            end
            default: state <= DIV_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed DIV/DIVU vectors with hand-computed results, latency, flush, hold and reset checks.
module tb_div_unit;
   import div_unit_pkg::*;
   logic clk = 0, rst = 0, validE = 0, flushE = 0, holdE = 0;
   logic [7:0] alucontrolE = 8'h00;
   logic [31:0] srcaE = 0, srcbE = 0, hi_out, lo_out;
   logic stall_div, div_ready;
   int checks = 0, failures = 0;
`ifdef DIV_ZERO_FAST_EN
   localparam int ZCYC = 1;
`else
   localparam int ZCYC = 33;
`endif
   div_unit dut (
      .clk        (clk),
      .rst        (rst),
      .alucontrolE(alucontrolE),
      .validE     (validE),
      .flushE     (flushE),
      .holdE      (holdE),
      .srcaE      (srcaE),
      .srcbE      (srcbE),
      .stall_div  (stall_div),
      .div_ready  (div_ready),
      .hi_out     (hi_out),
      .lo_out     (lo_out)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      alucontrolE = op;
      validE = 1;
      srcaE = a;
      srcbE = b;
      holdE = 0;
      #1;
   endtask
   task automatic run_div(input string tag, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] elo, input logic [31:0] ehi, input int ecyc, input int hold);
      int n;
      issue(op, a, b);
      n = 0;
      while (stall_div && n < 60) begin
         n++;
         @(negedge clk);
         #1;
      end
      chk({tag, "_cyc"}, n, ecyc);
      chk({tag, "_rdy"}, {31'b0, div_ready}, 1);
      chk({tag, "_lo"}, lo_out, elo);
      chk({tag, "_hi"}, hi_out, ehi);
      if (hold > 0) begin
         holdE = 1;
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            #1;
            chk({tag, "_hold_rdy"}, {31'b0, div_ready}, 1);
            chk({tag, "_hold_stall"}, {31'b0, stall_div}, 0);
            chk({tag, "_hold_lo"}, lo_out, elo);
         end
         holdE = 0;
      end
      @(negedge clk);
      validE = 0;
      #1;
      chk({tag, "_idle_rdy"}, {31'b0, div_ready}, 0);
   endtask
   initial begin
      logic seen;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_hi", hi_out, 0);
      chk("rst_lo", lo_out, 0);
      chk("rst_rdy", {31'b0, div_ready}, 0);
      chk("rst_stall", {31'b0, stall_div}, 0);
      rst = 1;
      issue(8'h20, 32'd100, 32'd7);
      repeat (3) begin
         chk("nondiv_stall", {31'b0, stall_div}, 0);
         @(negedge clk);
         #1;
      end
      chk("nondiv_rdy", {31'b0, div_ready}, 0);
      alucontrolE = EXE_DIV_OP;
      validE = 0;
      #1;
      chk("bubble_stall", {31'b0, stall_div}, 0);
      run_div("divu_100_7", EXE_DIVU_OP, 32'd100, 32'd7, 32'd14, 32'd2, 33, 0);
      run_div("div_m7_2", EXE_DIV_OP, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 33, 0);
      run_div("div_7_m2", EXE_DIV_OP, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 33, 0);
      run_div("divu_big", EXE_DIVU_OP, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 32'hF, 33, 0);
      run_div("div_ovf", EXE_DIV_OP, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 33, 0);
      issue(EXE_DIVU_OP, 32'd50, 32'd5);
      repeat (10) @(negedge clk);
      flushE = 1;
      #1;
      chk("flush_stall", {31'b0, stall_div}, 0);
      @(negedge clk);
      flushE = 0;
      validE = 0;
      #1;
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         #1;
         if (div_ready) seen = 1;
      end
      chk("flush_rdy", {31'b0, seen}, 0);
      chk("flush_lo", lo_out, 32'h80000000);
      chk("flush_hi", hi_out, 32'h0);
      run_div("divu_9_3_hold", EXE_DIVU_OP, 32'd9, 32'd3, 32'd3, 32'd0, 33, 3);
      run_div("divu_10_4", EXE_DIVU_OP, 32'd10, 32'd4, 32'd2, 32'd2, 33, 0);
      run_div("divu_5_0", EXE_DIVU_OP, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, ZCYC, 0);
      issue(EXE_DIVU_OP, 32'd100, 32'd7);
      repeat (5) @(negedge clk);
      rst = 0;
      validE = 0;
      @(negedge clk);
      rst = 1;
      #1;
      chk("midrst_hi", hi_out, 0);
      chk("midrst_lo", lo_out, 0);
      chk("midrst_rdy", {31'b0, div_ready}, 0);
      chk("midrst_stall", {31'b0, stall_div}, 0);
      run_div("after_rst", EXE_DIVU_OP, 32'd100, 32'd7, 32'd14, 32'd2, 33, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
